regfile_onehot_wr: RTL
======================

Name: regfile_onehot_wr

Overview:
- Eight-entry register bank that consumes the one-hot write-select vector produced by the 3-to-8 decoder_generic stage (enable-gated y[0:7]).
- Each cycle the decoder output selects at most one register to capture wr_data. A separate read port provides registered, 1-cycle-latency reads.
- Per-register "written" status bits are maintained.
- A sticky error flag is raised when the upstream select is not one-hot.

Parameters:
- WIDTH, 8, data width of each register.
- NREGS, 8, number of registers; equals decoder output count.
- ADDR_W, 3, read address width; NREGS <= 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- we_sel  input  [0:NREGS-1]  one-hot write select from decoder; we_sel[0] selects reg 0 (decoder w=0).
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read register index.
- clr_err  input  1  synchronous clear of sel_err.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse; rd_data is updated this cycle.
- rd_written  output  1  registered written bit of the register read.
- written  output  [NREGS-1:0]  per-register has-been-written flags.
- sel_err  output  1  sticky: a multi-hot we_sel was seen.

Behaviour:
- Reset (rst_n low, asynchronous, immediate): all registers=0, written=0, rd_data=0, rd_valid=0, rd_written=0, sel_err=0. Reset mid-operation discards any in-flight read; rd_valid stays 0 on the first edge after release.
- Write, evaluated at each posedge:
  - popcount(we_sel)==0: no write.
  - popcount(we_sel)==1 with bit i set: reg[i]<=wr_data and written[i]<=1.
  - popcount(we_sel)>=2: no register or written bit changes, and sel_err<=1.
- sel_err:
  - Stays set until clr_err is sampled high.
  - If clr_err and a new multi-hot select occur in the same cycle, the error wins and sel_err stays 1.
- Read:
  - When rd_en is sampled high at edge N, rd_data<=reg[rd_addr] and rd_written<=written[rd_addr]. rd_valid=1 during cycle N+1 only.
  - With rd_en low, rd_valid<=0 and rd_data/rd_written hold their last values.
  - Back-to-back rd_en gives one result per cycle, with rd_valid high continuously.
- Read-during-write to the same index in the same cycle: read-before-write. rd_data returns the old contents and rd_written the old flag; the new value is visible on the next read.
- Out-of-range read (rd_addr >= NREGS, only possible when NREGS < 2**ADDR_W): rd_data<=0, rd_written<=0, rd_valid still pulses.
- Width: wr_data is stored unmodified; no arithmetic. Writes to the same register overwrite it; no wrap or saturation concerns.
- written bits are monotonic (set only) until reset.

Test Plan:
- Reset → walking write: rst_n low 2 cycles, then we_sel=10000000,01000000…00000001 with wr_data=8'h10..8'h17 → written=8'hFF. Reads of addr 0..7 return 8'h10..8'h17 one cycle after each rd_en, with rd_valid pulsing each time and rd_written=1.
- Unwritten read: after reset, rd_en with rd_addr=5 → next cycle rd_data=0, rd_written=0, rd_valid=1 for exactly one cycle.
- Multi-hot select: we_sel=00110000, wr_data=8'hAA → reg2 and reg3 unchanged, sel_err=1 and stays 1 for 10 idle cycles. clr_err pulse → sel_err=0. clr_err together with we_sel=11000000 → sel_err remains 1.
- Read-during-write: reg4=8'h33, then in the same cycle we_sel=00001000/wr_data=8'h44 and rd_en/rd_addr=4 → rd_data=8'h33. Next read of 4 → 8'h44.
- Zero select / hold: we_sel=0 with wr_data toggling for 5 cycles → no register changes. rd_en low → rd_data holds the previous value and rd_valid=0.
- Async reset mid-read: rd_en at edge N, rst_n asserted between edges N and N+1 → rd_valid=0 and rd_data=0 immediately, with no clock edge needed; all written bits=0.

Source files
------------

// File: rtl/regfile_onehot_wr.sv
// Eight-entry register bank written through a one-hot decoder select, with a registered read port.
// Latency: writes land on the sampling edge; reads return one cycle after rd_en is sampled.
// Backpressure: none; every write and read is accepted, and a multi-hot select sets a sticky error.
module regfile_onehot_wr #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:NREGS-1]  we_sel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_written,
    output logic [NREGS-1:0]  written,
    output logic              sel_err
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             sel_seen;
    logic             multi_hot;
    logic             wr_ok;
    logic [WIDTH-1:0] rd_mux_data;
    logic             rd_mux_written;

    // A second set bit marks the select as multi-hot; exactly one set bit is a valid write.
    always_comb begin
        sel_seen  = 1'b0;
        multi_hot = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (we_sel[i]) begin
                if (sel_seen) begin
                    multi_hot = 1'b1;
                end
                sel_seen = 1'b1;
            end
        end
    end

    assign wr_ok = sel_seen && !multi_hot;

    // Indices with no backing register fall through to the zero defaults.
    always_comb begin
        rd_mux_data    = '0;
        rd_mux_written = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux_data    = regs[i];
                rd_mux_written = written[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            written <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NREGS; i++) begin
                if (we_sel[i]) begin
                    regs[i]    <= wr_data;
                    written[i] <= 1'b1;
                end
            end
        end
    end

    // A fresh error outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (multi_hot) begin
            sel_err <= 1'b1;
        end else if (clr_err) begin
            sel_err <= 1'b0;
        end
    end

    // The mux sees pre-write contents, giving read-before-write on a same-index collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data    <= '0;
            rd_written <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data    <= rd_mux_data;
                rd_written <= rd_mux_written;
            end
        end
    end

endmodule
